// File: rtl/sprite_pixel_fetch_if.sv
// Bundle of the pixel-in, sprite-memory and colour-out handshakes around sprite_pixel_fetch.
// The slave modport is the fetch block; master is everything around it.
interface sprite_pixel_fetch_if #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 16
);
  logic                  pixel_valid;
  logic                  pixel_ready;
  logic                  pixel_hit;
  logic [ADDR_WIDTH-1:0] pixel_address;
  logic [DATA_WIDTH-1:0] background;

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_color;

  modport master (
    output pixel_valid, pixel_hit, pixel_address, background,
    output mem_ack, mem_data,
    output out_ready,
    input  pixel_ready, mem_req, mem_address, out_valid, out_color
  );

  modport slave (
    input  pixel_valid, pixel_hit, pixel_address, background,
    input  mem_ack, mem_data,
    input  out_ready,
    output pixel_ready, mem_req, mem_address, out_valid, out_color
  );
endinterface

// File: rtl/sprite_pixel_fetch.sv
// Per-pixel sprite texel fetch: one req/ack memory read per hit, background substitution
// for misses and transparent texels, in-order colour FIFO toward the pixel output stage.
module sprite_pixel_fetch #(
  parameter int                    ADDR_WIDTH  = 23,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    FIFO_DEPTH  = 4,
  parameter logic [DATA_WIDTH-1:0] TRANSPARENT = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  sprite_pixel_fetch_if.slave  bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] resolve_color(
    input logic [DATA_WIDTH-1:0] texel,
    input logic [DATA_WIDTH-1:0] bg
  );
    return (texel == TRANSPARENT) ? bg : texel;
  endfunction

  state_t                state_p0;
  logic                  mem_req_p0;
  logic [ADDR_WIDTH-1:0] mem_addr_p0;
  logic [DATA_WIDTH-1:0] bg_p0;

  logic                  pixel_ready_c;
  logic                  accept_c;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] color_p1;
  logic                  pop_c;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  // Stage p0: accept a pixel and hold its context while the read is outstanding
  assign pixel_ready_c = (state_p0 == IDLE) && (count < CNT_W'(FIFO_DEPTH));
  assign accept_c      = bus.pixel_valid && pixel_ready_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= IDLE;
      mem_req_p0  <= 1'b0;
      mem_addr_p0 <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (accept_c) begin
            if (bus.pixel_hit) begin
              mem_addr_p0 <= bus.pixel_address;
              mem_req_p0  <= 1'b1;
              state_p0    <= FETCH;
            end else begin
              state_p0    <= FILL;
            end
          end
        end
        FETCH: begin
          if (bus.mem_ack) begin
            mem_req_p0 <= 1'b0;
            state_p0   <= IDLE;
          end
        end
        FILL: begin
          state_p0 <= IDLE;
        end
        default: begin
          mem_req_p0 <= 1'b0;
          state_p0   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept_c) begin
      bg_p0 <= bus.background;
    end
  end

  // Stage p1: resolved colour, pushed on ack (hit) or unconditionally (miss)
  assign vld_p1   = ((state_p0 == FETCH) && bus.mem_ack) || (state_p0 == FILL);
  assign color_p1 = (state_p0 == FILL) ? bg_p0 : resolve_color(bus.mem_data, bg_p0);
  assign pop_c    = (count != '0) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (vld_p1) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({vld_p1, pop_c})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entries past a reset are stale but unreachable, since count restarts at zero
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      fifo_mem[wr_ptr] <= color_p1;
    end
  end

  assign bus.pixel_ready = pixel_ready_c;
  assign bus.mem_req     = mem_req_p0;
  assign bus.mem_address = mem_addr_p0;
  assign bus.out_valid   = (count != '0);
  assign bus.out_color   = (count != '0) ? fifo_mem[rd_ptr] : '0;

endmodule

// File: doc/sprite_pixel_fetch.md
# sprite_pixel_fetch

Fetch stage directly downstream of the sprite output decoder. Per screen pixel it takes the winning sprite's 23-bit memory address (or a "no sprite" indication) and runs a req/ack read against sprite memory. It substitutes the background colour for misses and transparent texels, then buffers the resulting colours in order in a small FIFO for the pixel output stage.

## Interface
- ADDR_WIDTH, 23, sprite memory address width (matches decoder address output)
- DATA_WIDTH, 16, texel/colour width
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)
- TRANSPARENT, 0, texel value treated as transparent
- Clock  in  1  single clock; all logic on rising edge
- Reset  in  1  synchronous, active-high
- PixelValid  in  1  upstream offers a pixel
- PixelReady  out  1  block accepts a pixel this cycle
- PixelHit  in  1  1 = some sprite in range (PixelAddress valid), 0 = background only
- PixelAddress  in  ADDR_WIDTH  sprite memory address from decoder
- Background  in  DATA_WIDTH  background colour, sampled at accept
- MemReq  out  1  read request, held until acked
- MemAddress  out  ADDR_WIDTH  read address, stable while MemReq=1
- MemAck  in  1  one-cycle ack; MemData valid same cycle
- MemData  in  DATA_WIDTH  read data
- OutValid  out  1  FIFO non-empty
- OutReady  in  1  downstream pops when OutValid&OutReady
- OutColor  out  DATA_WIDTH  FIFO head colour

## Operation
- States: IDLE, FETCH, FILL.
- IDLE: PixelReady = (count < FIFO_DEPTH). On PixelValid&PixelReady: register Background; if PixelHit, register PixelAddress into MemAddress → FETCH; else → FILL.
- FETCH: MemReq=1. On MemAck: colour = (MemData==TRANSPARENT) ? registered Background : MemData; push; → IDLE. No timeout; wait indefinitely.
- FILL: push registered Background; → IDLE.
- At most one pixel in flight; output order equals accept order.
- PixelReady=0 outside IDLE. Since accept requires count<FIFO_DEPTH and pops only lower count, a push never overflows.
- FIFO: circular, pointers wrap modulo FIFO_DEPTH, count 0..FIFO_DEPTH. Push and pop in the same cycle leave count unchanged. A pop on empty cannot occur because OutValid=0.
- MemAck outside FETCH is ignored (no push, no state change).

## Timing
- Reset values: state IDLE, MemReq 0, MemAddress 0, FIFO empty, OutValid 0, OutColor 0, PixelReady 1 (from cycle after reset deassert).
- Reset mid-fetch: MemReq low next cycle, in-flight pixel and FIFO contents discarded; a subsequent late MemAck is ignored.
- Accept at cycle N → MemReq high from N+1; ack at cycle M ≥ N+1 → OutValid at M+1 (if FIFO was empty). Minimum hit latency 2 cycles.
- Miss: accept N, push at end of N+1, OutValid N+2.
- Peak throughput one pixel per 2 cycles (miss or zero-wait hit).
- MemReq deasserts the cycle after MemAck. MemAddress holds until next accept.
- OutColor/OutValid are registered FIFO outputs, with no combinational path from PixelValid or MemAck.

## Test plan
- Reset then miss: Background=16'h1234, PixelHit=0, accept cycle 0 → no MemReq; OutValid=1, OutColor=16'h1234 at cycle 2.
- Zero-wait hit: PixelAddress=23'h00ABCD, MemAck with MemData=16'hBEEF in cycle 1 → MemAddress=23'h00ABCD while MemReq high; OutColor=16'hBEEF at cycle 2; PixelReady back high cycle 2.
- Transparent: hit with MemData=16'h0000, Background=16'h00F0 → OutColor=16'h00F0; stalled ack (3 wait cycles) keeps MemReq and MemAddress stable, PixelReady=0.
- Full/ordering: OutReady=0, feed 5 pixels of colours 1..5 → first 4 stored, PixelReady=0 after 4th; raise OutReady → pops 1,2,3,4, then 5th accepted and output; no loss or reorder.
- Simultaneous push/pop: count=2, push and pop same cycle → count stays 2, pointers wrap correctly over 3 full laps.
- Reset in FETCH: assert Reset with MemReq=1, then MemAck next cycle → MemReq=0, OutValid=0, no push.
